// File: rtl/mod_exp_ladder_pkg.sv
// Shared constants for the Montgomery-ladder modular exponentiator:
// default operand widths and the controller state encoding.
package mod_exp_ladder_pkg;

    localparam int DEF_WIDTH = 1024;
    localparam int DEF_LENW  = 32;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TOMONT   = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_LOOP     = 3'd3;
    localparam logic [2:0] S_FROMMONT = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

endpackage

// File: rtl/mod_exp_ladder_montgomery.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// Ports: clk, resetn (sync, active-low), start (accepted when idle),
//        a, b, m (odd, b < m), p (held until next start), done (1-cycle pulse).
module montgomery
    import mod_exp_ladder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] sum_q;
    logic [WIDTH:0]   diff;

    // acc stays below 2m, so one extra bit plus one for the add suffices.
    always_comb begin
        sum   = {1'b0, acc} + (a_q[0] ? {2'b00, b_q} : '0);
        sum_q = sum[0] ? sum + {2'b00, m_q} : sum;
    end

    // Final conditional subtraction is done on the output path.
    always_comb begin
        diff = acc - {1'b0, m_q};
        p    = (acc >= {1'b0, m_q}) ? diff[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q  <= '0;
            b_q  <= '0;
            m_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                a_q <= a;
                b_q <= b;
                m_q <= m;
                acc <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                acc <= sum_q[WIDTH+1:1];
                a_q <= a_q >> 1;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mod_exp_ladder.sv
// Montgomery-ladder modular exponentiation: result = in_x^in_e mod in_m.
// Ports: clk, resetn (sync, active-low), start, in_x/in_m/in_e/in_r/in_r2,
//        lene (exponent bits, MSB first), result, done (pulse), busy.
// Option: define LADDER_SKIP_LZ_EN to skip leading zero exponent bits.
module mod_exp_ladder
    import mod_exp_ladder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [LENW-1:0]  lene,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    logic [2:0]       state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] r2_q;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_x;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    len_c;
    logic [IW-1:0]    idx;
    logic             ebit;
    logic             go;
    logic             seen1;
    logic             seen2;
    logic             fin1;
    logic             fin2;
`ifdef LADDER_SKIP_LZ_EN
    logic             lead;
`endif

    logic [WIDTH-1:0] op1_a;
    logic [WIDTH-1:0] op1_b;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p2;
    logic             done1;
    logic             done2;
    logic             start2;

    // cnt holds the number of exponent bits still to process.
    always_comb begin
        if (64'(lene) > 64'(WIDTH))
            len_c = CW'(WIDTH);
        else
            len_c = CW'(lene);
    end

    assign idx  = IW'(cnt - CW'(1));
    assign ebit = e_q[idx];
    assign fin1 = done1 | seen1;
    assign fin2 = done2 | seen2;

    // Multiplier 1 forms the A*X product (and the domain conversions);
    // multiplier 2 squares whichever accumulator the current bit selects.
    always_comb begin
        op1_a = acc_a;
        op1_b = acc_x;
        op2   = ebit ? acc_x : acc_a;
        case (state)
            S_TOMONT: begin
                op1_a = x_q;
                op1_b = r2_q;
            end
            S_FROMMONT: begin
                op1_a = acc_a;
                op1_b = WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign start2 = go && (state == S_LOOP);

    montgomery #(.WIDTH(WIDTH)) u_mul_prod (
        .clk    (clk),
        .resetn (resetn),
        .start  (go),
        .a      (op1_a),
        .b      (op1_b),
        .m      (m_q),
        .p      (p1),
        .done   (done1)
    );

    montgomery #(.WIDTH(WIDTH)) u_mul_sqr (
        .clk    (clk),
        .resetn (resetn),
        .start  (start2),
        .a      (op2),
        .b      (op2),
        .m      (m_q),
        .p      (p2),
        .done   (done2)
    );

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            x_q    <= '0;
            m_q    <= '0;
            e_q    <= '0;
            r2_q   <= '0;
            acc_a  <= '0;
            acc_x  <= '0;
            cnt    <= '0;
            go     <= 1'b0;
            seen1  <= 1'b0;
            seen2  <= 1'b0;
            result <= '0;
`ifdef LADDER_SKIP_LZ_EN
            lead   <= 1'b0;
`endif
        end else begin
            go <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= in_x;
                        m_q   <= in_m;
                        e_q   <= in_e;
                        r2_q  <= in_r2;
                        acc_a <= in_r;
                        acc_x <= '0;
                        cnt   <= len_c;
                        go    <= 1'b1;
                        state <= S_TOMONT;
`ifdef LADDER_SKIP_LZ_EN
                        lead  <= 1'b1;
`endif
                    end
                end
                S_TOMONT: begin
                    if (done1) begin
                        acc_x <= p1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (cnt == '0) begin
                        go    <= 1'b1;
                        state <= S_FROMMONT;
                    end else begin
`ifdef LADDER_SKIP_LZ_EN
                        // Leading zeros leave A=1, X=x unchanged: skip them.
                        if (lead && !ebit) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            lead  <= 1'b0;
                            go    <= 1'b1;
                            state <= S_LOOP;
                        end
`else
                        go    <= 1'b1;
                        state <= S_LOOP;
`endif
                    end
                end
                S_LOOP: begin
                    if (done1) seen1 <= 1'b1;
                    if (done2) seen2 <= 1'b1;
                    if (fin1 && fin2) begin
                        seen1 <= 1'b0;
                        seen2 <= 1'b0;
                        if (ebit) begin
                            acc_a <= p1;
                            acc_x <= p2;
                        end else begin
                            acc_x <= p1;
                            acc_a <= p2;
                        end
                        cnt   <= cnt - CW'(1);
                        state <= S_SCAN;
                    end
                end
                S_FROMMONT: begin
                    if (done1) begin
                        acc_a  <= p1;
                        result <= p1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
